// File: rtl/dma_ip_ctrl_axil_master.sv
// Purpose : AXI4-Lite master for the DMA IP control slave. Each command becomes one
//           write, one read, or a bounded poll loop of single reads.
// Latency : accept to rsp_valid is 3 cycles minimum for read and write, and 1 cycle for the
//           reserved op. A poll adds POLL_GAP idle cycles plus one read per retry.
// Backpr. : one command in flight. cmd_ready is high only in IDLE. The response is held until
//           rsp_ready. A stalled slave channel stalls the master indefinitely.
// Ports   : ACLK/ARESET; cmd_* request (op, addr, wdata or poll mask, wstrb);
//           rsp_* response (data, resp, timeout); busy; AXI4-Lite AW/W/B/AR/R master channels.
module dma_ip_ctrl_axil_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 6,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int POLL_GAP           = 16,
   parameter int POLL_LIMIT         = 1024
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   // command / response
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [1:0]                        cmd_op,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   output logic                              busy,
   // AXI4-Lite write address / data / response
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     AWADDR,
   output logic                              AWVALID,
   input  logic                              AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
   output logic                              WVALID,
   input  logic                              WREADY,
   input  logic [1:0]                        BRESP,
   input  logic                              BVALID,
   output logic                              BREADY,
   // AXI4-Lite read address / data
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     ARADDR,
   output logic                              ARVALID,
   input  logic                              ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     RDATA,
   input  logic [1:0]                        RRESP,
   input  logic                              RVALID,
   output logic                              RREADY
);

   localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
   localparam int GAP_W  = $clog2(POLL_GAP + 1);
   localparam logic [PCNT_W-1:0] LAST_POLL = PCNT_W'(POLL_LIMIT - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_POLL  = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR_DATA,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_POLL_WAIT,
      S_RSP
   } state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      op_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]   mask_q;
   logic [PCNT_W-1:0]               poll_cnt_q;
   logic [GAP_W-1:0]                gap_cnt_q;
   logic                            aw_done, w_done, poll_hit, poll_more;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state / outputs
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      busy      = (state_q != S_IDLE);
      // A channel counts as done once its VALID has dropped or is handshaking now.
      aw_done   = !AWVALID || AWREADY;
      w_done    = !WVALID  || WREADY;
      poll_hit  = (RDATA & mask_q) != '0;
      // Another poll read is due only for a poll op that missed and still has budget.
      poll_more = (op_q == OP_POLL) && !poll_hit && (poll_cnt_q != LAST_POLL);

      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               unique case (cmd_op)
                  OP_WRITE:         state_d = S_WADDR_DATA;
                  OP_READ, OP_POLL: state_d = S_RADDR;
                  default:          state_d = S_RSP;
               endcase
            end
         end
         S_WADDR_DATA: if (aw_done && w_done) state_d = S_WRESP;
         S_WRESP: begin
            BREADY = 1'b1;
            if (BVALID) state_d = S_RSP;
         end
         S_RADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) state_d = S_RDATA;
         end
         S_RDATA: begin
            RREADY = 1'b1;
            if (RVALID) state_d = poll_more ? S_POLL_WAIT : S_RSP;
         end
         // The counter is loaded with POLL_GAP, so leaving on 1 gives exactly POLL_GAP idle cycles.
         S_POLL_WAIT: if (gap_cnt_q == GAP_W'(1)) state_d = S_RADDR;
         S_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         op_q        <= OP_WRITE;
         mask_q      <= '0;
         AWADDR      <= '0;
         ARADDR      <= '0;
         WDATA       <= '0;
         WSTRB       <= '0;
         AWVALID     <= 1'b0;
         WVALID      <= 1'b0;
         poll_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         rsp_data    <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (cmd_valid) begin
               op_q        <= cmd_op;
               mask_q      <= cmd_wdata;
               AWADDR      <= cmd_addr;
               ARADDR      <= cmd_addr;
               WDATA       <= cmd_wdata;
               WSTRB       <= cmd_wstrb;
               poll_cnt_q  <= '0;
               rsp_timeout <= 1'b0;
               if (cmd_op == OP_WRITE) begin
                  AWVALID <= 1'b1;
                  WVALID  <= 1'b1;
               end
               if (cmd_op == OP_RSVD) begin
                  rsp_resp <= 2'b10;
                  rsp_data <= '0;
               end
            end
            S_WADDR_DATA: begin
               if (AWREADY) AWVALID <= 1'b0;
               if (WREADY)  WVALID  <= 1'b0;
            end
            S_WRESP: if (BVALID) begin
               rsp_resp <= BRESP;
               rsp_data <= '0;
            end
            S_RDATA: if (RVALID) begin
               // Every beat is captured once; a clear-on-read value is never re-fetched.
               rsp_data <= RDATA;
               rsp_resp <= RRESP;
               if (poll_more) begin
                  poll_cnt_q <= poll_cnt_q + 1'b1;
                  gap_cnt_q  <= GAP_LOAD;
               end else if (op_q == OP_POLL && !poll_hit) begin
                  rsp_timeout <= 1'b1;
               end
            end
            S_POLL_WAIT: gap_cnt_q <= gap_cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dma_ip_ctrl_axil_master.md
Name: dma_ip_ctrl_axil_master

Overview:
AXI4-Lite master that drives the DMA IP control slave. It turns simple command/response handshakes into single AXI4-Lite write or read transactions. A poll command repeatedly reads one register until a masked bit is set or a poll limit is reached, for example waiting on ap_done in AP_CTRL at 0x00. It sits between the host-side sequencer (or testbench driver) and the control slave's AXI4-Lite port.

Parameters:
C_M_AXI_ADDR_WIDTH, 6, AXI address width; matches the slave register map (0x00-0x24).
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
POLL_GAP, 16, idle cycles between consecutive poll reads (minimum 1).
POLL_LIMIT, 1024, maximum number of reads issued by one poll command (minimum 1).

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESET  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accept; high only in IDLE.
cmd_op  in  2  0=write, 1=read, 2=poll, 3=reserved.
cmd_addr  in  ADDR_W  target register byte address.
cmd_wdata  in  32  write data (write); bit mask (poll).
cmd_wstrb  in  4  byte strobes (write only).
rsp_valid  out  1  response available.
rsp_ready  in  1  response accept.
rsp_data  out  32  read data; last read value for poll; 0 for write.
rsp_resp  out  2  BRESP or RRESP of the last beat; 2'b10 for reserved op.
rsp_timeout  out  1  poll ended on POLL_LIMIT without a match.
busy  out  1  high whenever state is not IDLE.
AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master side, same widths as the control slave.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All VALID/READY outputs and rsp_valid are 0.
  - rsp_data, rsp_resp, rsp_timeout, AWADDR, WDATA, WSTRB and ARADDR are 0.
  - Poll and gap counters are 0.
  - Reset mid-transaction abandons the transaction and issues no response.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, POLL_WAIT, RSP.
- IDLE:
  - cmd_ready=1; a command is accepted on cmd_valid&cmd_ready, and all cmd_* fields are registered.
  - Op 0 -> WADDR_DATA. Op 1 or 2 -> RADDR, with poll count cleared. Op 3 -> RSP with rsp_resp=2'b10, rsp_data=0 and no bus activity.
- WADDR_DATA:
  - AWVALID and WVALID both rise in the cycle after accept.
  - Each drops independently on its own handshake (AWVALID&AWREADY, WVALID&WREADY). AW may complete before W, after W, or in the same cycle.
  - When both are done -> WRESP.
  - AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WRESP: BREADY=1. On BVALID, capture BRESP into rsp_resp, set rsp_data=0 -> RSP.
- RADDR: ARVALID=1 with ARADDR stable; on ARREADY -> RDATA.
- RDATA:
  - RREADY=1. On RVALID, capture RDATA into rsp_data and RRESP into rsp_resp.
  - Read op -> RSP.
  - Poll op, match ((RDATA & mask) != 0) -> RSP with rsp_timeout=0.
  - Poll op, no match, poll count == POLL_LIMIT-1 -> RSP with rsp_timeout=1.
  - Poll op, no match otherwise -> increment poll count, load gap counter with POLL_GAP -> POLL_WAIT.
  - Poll does not stop on a non-OKAY RRESP; the last RRESP is reported.
- POLL_WAIT: decrement the gap counter each cycle; on reaching 0 -> RADDR. No bus signals are asserted.
- RSP:
  - rsp_valid=1, with rsp_* held stable until rsp_ready. The handshake takes 1 cycle -> IDLE.
  - cmd_ready is 0 throughout, so a new command is accepted no earlier than the cycle after the response handshake.
- Mask 0 never matches: the poll runs exactly POLL_LIMIT reads, then reports timeout=1.
- Clear-on-read side effects in the slave (done/ready bits) are captured exactly once in rsp_data. The master never issues a speculative read.
- Exactly one AXI transaction is outstanding at any time. No per-beat watchdog: a stalled slave stalls the master.
- Minimum latency, accept to rsp_valid:
  - Write with AW/W ready at once: 3 cycles.
  - Read: 3 cycles.

Test Plan:
- Write 0x10 = 0x00000100, wstrb 0xF; slave asserts AWREADY at once and WREADY 3 cycles later -> AWVALID drops after 1 cycle, WVALID holds 3 cycles; one B beat; rsp_resp=0, rsp_data=0; slave register reads back 0x00000100.
- Read 0x24 after the slave holds 0x0000002A -> exactly one AR handshake; rsp_data=0x0000002A, rsp_resp=0, rsp_timeout=0.
- Poll 0x00, mask 0x2, POLL_GAP=4; slave sets ap_done before the 5th read -> exactly 5 AR handshakes, 4 idle cycles between each; rsp_data bit1=1, rsp_timeout=0.
- Poll 0x00, mask 0x2, POLL_LIMIT=4, done never set -> exactly 4 reads; rsp_timeout=1; rsp_data = last read value.
- cmd_op=3 -> no AW/W/AR activity; rsp_valid one cycle after accept with rsp_resp=2'b10. Separately, rsp_ready held low for 10 cycles -> rsp_* stable and cmd_ready=0 throughout.
- ARESET pulsed asynchronously while AWVALID=1 and WVALID=1 -> all VALIDs and rsp_valid drop before the next ACLK edge; no response is produced; the next command completes normally.
